sr_cntr_sum_n: RTL

SR_CNTR_SUM_N -- requirements
Module: sr_cntr_sum_n

---
 rtl/sr_cntr_sum_n.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sr_cntr_sum_n.sv
// Per-channel serial shift registers with loadable up/down counters, plus a
// sequential summing FSM over a snapshot of all counters. Optional macro SR_CNTR_SUM_SAT_EN.

module sr_cntr_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             d,
    input  logic             shift_en,
    input  logic             cnt_en,
    input  logic [1:0]       cnt_op,
    input  logic             inc,
    output logic [WIDTH-1:0] sr,
    output logic [WIDTH-1:0] cnt
);
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] cnt_next;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x, input logic up);
`ifdef SR_CNTR_SUM_SAT_EN
        if (up && (&x)) return x;
        if (!up && (x == '0)) return x;
`endif
        return up ? x + 1'b1 : x - 1'b1;
    endfunction

    always_comb begin
        sr_next = shift_en ? {sr[WIDTH-2:0], d} : sr;
    end

    // op 10 reads sr before this edge's shift, since sr is the registered value
    always_comb begin
        cnt_next = cnt;
        if (cnt_en) begin
            unique case (cnt_op)
                2'b00:   cnt_next = cnt;
                2'b01:   cnt_next = step(cnt, inc);
                2'b10:   cnt_next = step(sr, inc);
                default: cnt_next = sr;
            endcase
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sr  <= '0;
            cnt <= '0;
        end else begin
            sr  <= sr_next;
            cnt <= cnt_next;
        end
    end
endmodule

module sr_cntr_sum_n #(
    parameter int WIDTH = 8,
    parameter int CH    = 2,
    parameter int SUMW  = WIDTH + $clog2(CH)
) (
    input  logic                clk,
    input  logic                res,
    input  logic [CH-1:0]       d,
    input  logic                shift_en,
    input  logic                cnt_en,
    input  logic [1:0]          cnt_op,
    input  logic                inc,
    input  logic                start,
    output logic [CH*WIDTH-1:0] sr_q,
    output logic [CH*WIDTH-1:0] cnt_q,
    output logic [SUMW-1:0]     sum,
    output logic                sum_valid,
    output logic                busy,
    output logic                ovf
);
    localparam int IDXW = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    logic [CH-1:0][WIDTH-1:0] sr_a;
    logic [CH-1:0][WIDTH-1:0] cnt_a;
    logic [CH-1:0][WIDTH-1:0] snap;
    logic [SUMW-1:0]          acc;
    logic [IDXW-1:0]          idx;
    logic                     acc_hi;
    logic                     last;
    state_t                   state, state_next;

    for (genvar c = 0; c < CH; c++) begin : g_lane
        sr_cntr_lane #(.WIDTH(WIDTH)) u_lane (
            .clk      (clk),
            .res      (res),
            .d        (d[c]),
            .shift_en (shift_en),
            .cnt_en   (cnt_en),
            .cnt_op   (cnt_op),
            .inc      (inc),
            .sr       (sr_a[c]),
            .cnt      (cnt_a[c])
        );
    end

    assign sr_q  = sr_a;
    assign cnt_q = cnt_a;
    assign last  = (idx == IDXW'(CH - 1));

    if (CH > 1) begin : g_ovf
        assign acc_hi = |acc[SUMW-1:WIDTH];
    end else begin : g_no_ovf
        assign acc_hi = 1'b0;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = ACC;
            ACC:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == ACC) || (state == DONE);
        sum_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            snap <= '0;
            acc  <= '0;
            idx  <= '0;
            sum  <= '0;
            ovf  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    snap <= cnt_a;
                    acc  <= '0;
                    idx  <= '0;
                end
                ACC: begin
                    acc <= acc + SUMW'(snap[idx]);
                    idx <= idx + 1'b1;
                end
                DONE: begin
                    sum <= acc;
                    ovf <= acc_hi;
                end
                default: ;
            endcase
        end
    end
endmodule
